icache_tag_ctrl: RTL and testbench

- Sequences and arbitrates the single-port icache tag RAM (1 RAM access per cycle; write-through rdata; 1-cycle read latency).
- Shares the port between three sources:
  - fetch-side lookups;
  - miss-handler refill writes;
  - an internal invalidation walker used at reset and on fence.i flush.
- Produces the registered hit/miss result for the icache top.

---
 rtl/icache_tag_ctrl.sv | 135 +++++++++++++
 tb/tb_icache_tag_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_tag_ctrl.sv
// Tag RAM port sequencer: arbitrates flush walk > refill write > fetch lookup on one single-port RAM.
// Latency: lookup result one cycle after lkup_gnt; refill_ack same cycle; walk is NUM_SETS cycles.
// Backpressure: lkup_gnt/refill_ack low while a higher-priority source owns the port; ICACHE_TAG_PARITY_EN adds a parity bit.
module icache_tag_ctrl #(
    parameter int NUM_SETS = 128,
    parameter int IDX_W    = $clog2(NUM_SETS),
    parameter int TAG_W    = 20,
`ifdef ICACHE_TAG_PARITY_EN
    parameter int ENTRY_W  = TAG_W + 2
`else
    parameter int ENTRY_W  = TAG_W + 1
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_req,
    output logic               flush_busy,
    input  logic               lkup_req,
    input  logic [IDX_W-1:0]   lkup_idx,
    input  logic [TAG_W-1:0]   lkup_tag,
    output logic               lkup_gnt,
    output logic               rsp_valid,
    output logic               rsp_hit,
`ifdef ICACHE_TAG_PARITY_EN
    output logic               parity_err,
`endif
    input  logic               refill_req,
    input  logic [IDX_W-1:0]   refill_idx,
    input  logic [TAG_W-1:0]   refill_tag,
    output logic               refill_ack,
    output logic               tr_req,
    output logic               tr_wr_en,
    output logic [IDX_W-1:0]   tr_addr,
    output logic [ENTRY_W-1:0] tr_wdata,
    input  logic [ENTRY_W-1:0] tr_rdata
);

    typedef enum logic [1:0] {INIT, IDLE, FLUSH} state_t;

    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

    state_t             state, state_d;
    logic [IDX_W-1:0]   cnt, cnt_d;
    logic               flush_pend, flush_pend_d;
    logic [TAG_W-1:0]   tag_q;
    logic [ENTRY_W-1:0] refill_entry;
    logic               tag_match;
    logic               par_bad;

`ifdef ICACHE_TAG_PARITY_EN
    assign refill_entry = {^{1'b1, refill_tag}, 1'b1, refill_tag};
    assign par_bad      = ^tr_rdata;
    assign parity_err   = rsp_valid & par_bad;
`else
    assign refill_entry = {1'b1, refill_tag};
    assign par_bad      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            flush_pend <= flush_pend_d;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        flush_pend_d = flush_pend;
        flush_busy   = 1'b0;
        tr_req       = 1'b0;
        tr_wr_en     = 1'b0;
        tr_addr      = cnt;
        tr_wdata     = '0;
        lkup_gnt     = 1'b0;
        refill_ack   = 1'b0;
        case (state)
            INIT, FLUSH: begin
                flush_busy = 1'b1;
                tr_req     = 1'b1;
                tr_wr_en   = 1'b1;
                cnt_d      = cnt + IDX_W'(1);
                // A flush queued during the walk chains straight into a new walk.
                if (cnt == LAST_SET) begin
                    if (flush_pend || flush_req) begin
                        state_d      = FLUSH;
                        flush_pend_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (flush_req) begin
                    flush_pend_d = 1'b1;
                end
            end
            IDLE: begin
                if (flush_req || flush_pend) begin
                    state_d      = FLUSH;
                    cnt_d        = '0;
                    flush_pend_d = 1'b0;
                end else if (refill_req) begin
                    tr_req     = 1'b1;
                    tr_wr_en   = 1'b1;
                    tr_addr    = refill_idx;
                    tr_wdata   = refill_entry;
                    refill_ack = 1'b1;
                end else if (lkup_req) begin
                    tr_req   = 1'b1;
                    tr_addr  = lkup_idx;
                    lkup_gnt = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            tag_q     <= '0;
        end else begin
            rsp_valid <= lkup_gnt;
            if (lkup_gnt) tag_q <= lkup_tag;
        end
    end

    // RAM read data lands in the response cycle, so the compare is combinational.
    assign tag_match = tr_rdata[TAG_W] & (tr_rdata[TAG_W-1:0] == tag_q);
    assign rsp_hit   = rsp_valid & tag_match & ~par_bad;

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Directed bench for icache_tag_ctrl with a behavioural single-port tag RAM.
module tb_icache_tag_ctrl;

    localparam int NUM_SETS = 128;
    localparam int IDX_W    = 7;
    localparam int TAG_W    = 20;
`ifdef ICACHE_TAG_PARITY_EN
    localparam int ENTRY_W  = TAG_W + 2;
`else
    localparam int ENTRY_W  = TAG_W + 1;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               flush_req;
    logic               flush_busy;
    logic               lkup_req;
    logic [IDX_W-1:0]   lkup_idx;
    logic [TAG_W-1:0]   lkup_tag;
    logic               lkup_gnt;
    logic               rsp_valid;
    logic               rsp_hit;
`ifdef ICACHE_TAG_PARITY_EN
    logic               parity_err;
`endif
    logic               refill_req;
    logic [IDX_W-1:0]   refill_idx;
    logic [TAG_W-1:0]   refill_tag;
    logic               refill_ack;
    logic               tr_req;
    logic               tr_wr_en;
    logic [IDX_W-1:0]   tr_addr;
    logic [ENTRY_W-1:0] tr_wdata;
    logic [ENTRY_W-1:0] tr_rdata;

    logic [ENTRY_W-1:0] ram [NUM_SETS];
    logic [ENTRY_W-1:0] ram_q     = '0;
    logic [ENTRY_W-1:0] flip_mask = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    icache_tag_ctrl #(.NUM_SETS(NUM_SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .ENTRY_W(ENTRY_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .lkup_req   (lkup_req),
        .lkup_idx   (lkup_idx),
        .lkup_tag   (lkup_tag),
        .lkup_gnt   (lkup_gnt),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
`ifdef ICACHE_TAG_PARITY_EN
        .parity_err (parity_err),
`endif
        .refill_req (refill_req),
        .refill_idx (refill_idx),
        .refill_tag (refill_tag),
        .refill_ack (refill_ack),
        .tr_req     (tr_req),
        .tr_wr_en   (tr_wr_en),
        .tr_addr    (tr_addr),
        .tr_wdata   (tr_wdata),
        .tr_rdata   (tr_rdata)
    );

    // Single-port RAM, write-through read data, one-cycle read latency.
    always @(posedge clk) begin
        if (tr_req) begin
            if (tr_wr_en) begin
                ram[tr_addr] <= tr_wdata;
                ram_q        <= tr_wdata;
            end else begin
                ram_q <= ram[tr_addr];
            end
        end
    end
    assign tr_rdata = ram_q ^ flip_mask;

    function automatic logic [ENTRY_W-1:0] entry_of(input logic [TAG_W-1:0] tag);
`ifdef ICACHE_TAG_PARITY_EN
        return {^{1'b1, tag}, 1'b1, tag};
`else
        return {1'b1, tag};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Starts at a negedge; counts walk cycles, ends at negedge+1 in IDLE.
    task automatic count_walk(input string nm, input int exp_cycles, input int pulse_at);
        int busy = 0;
        bit done = 0;
        lkup_req = 1'b1;
        lkup_idx = '0;
        lkup_tag = '0;
        for (int c = 0; c < 600 && !done; c++) begin
            #1;
            if (!flush_busy) begin
                done = 1;
            end else begin
                check({nm, " addr"}, 32'(tr_addr), 32'(busy % NUM_SETS));
                check({nm, " wdata"}, 32'(tr_wdata), 32'd0);
                check({nm, " wr_en"}, 32'(tr_wr_en), 32'd1);
                check({nm, " gnt"}, 32'(lkup_gnt), 32'd0);
                if (busy == pulse_at) flush_req = 1'b1;
                @(negedge clk);
                flush_req = 1'b0;
                busy++;
            end
        end
        check({nm, " cycles"}, 32'(busy), 32'(exp_cycles));
        check({nm, " idle gnt"}, 32'(lkup_gnt), 32'd1);
        lkup_req = 1'b0;
    endtask

    task automatic refill(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag, input string nm);
        refill_req = 1'b1;
        refill_idx = idx;
        refill_tag = tag;
        #1;
        check({nm, " ack"}, 32'(refill_ack), 32'd1);
        check({nm, " wr_en"}, 32'(tr_wr_en), 32'd1);
        check({nm, " addr"}, 32'(tr_addr), 32'(idx));
        check({nm, " wdata"}, 32'(tr_wdata), 32'(entry_of(tag)));
        @(negedge clk);
        refill_req = 1'b0;
    endtask

    task automatic lookup(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                          input logic exp_hit, input string nm);
        lkup_req = 1'b1;
        lkup_idx = idx;
        lkup_tag = tag;
        #1;
        check({nm, " gnt"}, 32'(lkup_gnt), 32'd1);
        check({nm, " addr"}, 32'(tr_addr), 32'(idx));
        check({nm, " rd"}, 32'(tr_wr_en), 32'd0);
        @(negedge clk);
        lkup_req = 1'b0;
        #1;
        check({nm, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({nm, " rsp_hit"}, 32'(rsp_hit), 32'(exp_hit));
`ifdef ICACHE_TAG_PARITY_EN
        check({nm, " parity_err"}, 32'(parity_err), 32'd0);
`endif
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        flush_req = 1'b0;
        lkup_req = 1'b0;
        lkup_idx = '0;
        lkup_tag = '0;
        refill_req = 1'b0;
        refill_idx = '0;
        refill_tag = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset flush_busy", 32'(flush_busy), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_hit", 32'(rsp_hit), 32'd0);
        check("reset addr", 32'(tr_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_walk("init walk", 128, -1);
        @(negedge clk);

        refill(7'd5, 20'hABCDE, "refill5");
        lookup(7'd5, 20'hABCDE, 1'b1, "lkup5 hit");
        #1;
        check("rsp_valid drops", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        lookup(7'd5, 20'h12345, 1'b0, "lkup5 wrong tag");
        lookup(7'd6, 20'hABCDE, 1'b0, "lkup6 invalid");

        // Back-to-back lookups: one response per cycle.
        lkup_req = 1'b1; lkup_idx = 7'd5; lkup_tag = 20'hABCDE;
        @(negedge clk);
        lkup_tag = 20'h12345;
        #1;
        check("b2b rsp0 valid", 32'(rsp_valid), 32'd1);
        check("b2b rsp0 hit", 32'(rsp_hit), 32'd1);
        check("b2b gnt1", 32'(lkup_gnt), 32'd1);
        @(negedge clk);
        lkup_req = 1'b0;
        #1;
        check("b2b rsp1 valid", 32'(rsp_valid), 32'd1);
        check("b2b rsp1 hit", 32'(rsp_hit), 32'd0);
        @(negedge clk);

        // Refill beats a simultaneous lookup; the retried lookup sees the new tag.
        lkup_req = 1'b1; lkup_idx = 7'd7; lkup_tag = 20'h55555;
        refill_req = 1'b1; refill_idx = 7'd7; refill_tag = 20'h55555;
        #1;
        check("collide ack", 32'(refill_ack), 32'd1);
        check("collide gnt", 32'(lkup_gnt), 32'd0);
        @(negedge clk);
        refill_req = 1'b0;
        lookup(7'd7, 20'h55555, 1'b1, "retry lkup7");

        // Flush with a second flush queued mid-walk.
        lkup_req = 1'b1; lkup_idx = 7'd5; lkup_tag = 20'hABCDE;
        flush_req = 1'b1;
        #1;
        check("flush start tr_req", 32'(tr_req), 32'd0);
        check("flush start gnt", 32'(lkup_gnt), 32'd0);
        @(negedge clk);
        flush_req = 1'b0;
        count_walk("double flush", 256, 50);
        @(negedge clk);
        lookup(7'd5, 20'hABCDE, 1'b0, "lkup5 after flush");
        lookup(7'd7, 20'h55555, 1'b0, "lkup7 after flush");

        // Lookup granted the cycle before flush still reports.
        refill(7'd9, 20'h0F0F0, "refill9");
        lkup_req = 1'b1; lkup_idx = 7'd9; lkup_tag = 20'h0F0F0;
        #1;
        check("pre-flush gnt", 32'(lkup_gnt), 32'd1);
        @(negedge clk);
        lkup_req = 1'b0;
        flush_req = 1'b1;
        #1;
        check("pre-flush rsp_valid", 32'(rsp_valid), 32'd1);
        check("pre-flush rsp_hit", 32'(rsp_hit), 32'd1);
        check("pre-flush tr_req", 32'(tr_req), 32'd0);
        @(negedge clk);
        flush_req = 1'b0;
        count_walk("flush9", 128, -1);
        @(negedge clk);
        lookup(7'd9, 20'h0F0F0, 1'b0, "lkup9 after flush");

`ifdef ICACHE_TAG_PARITY_EN
        refill(7'd3, 20'h13579, "refill3");
        lookup(7'd3, 20'h13579, 1'b1, "lkup3 clean");
        lkup_req = 1'b1; lkup_idx = 7'd3; lkup_tag = 20'h13579;
        @(negedge clk);
        lkup_req = 1'b0;
        flip_mask = ENTRY_W'(1) << 4;
        #1;
        check("parity rsp_valid", 32'(rsp_valid), 32'd1);
        check("parity rsp_hit", 32'(rsp_hit), 32'd0);
        check("parity err", 32'(parity_err), 32'd1);
        @(negedge clk);
        flip_mask = '0;
        #1;
        check("parity err clears", 32'(parity_err), 32'd0);
        @(negedge clk);
`endif

        // Reset mid-walk restarts from set 0.
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("midwalk addr before rst", 32'(tr_addr), 32'd10);
        rst = 1'b1;
        #1;
        check("midwalk rst busy", 32'(flush_busy), 32'd1);
        check("midwalk rst addr", 32'(tr_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_walk("restart walk", 128, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
